// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: dm op codes, arbiter states and op legality helpers shared with the pipeline
package dm_arb_pkg;
    localparam logic [2:0] DM_OP_WD = 3'd0;
    localparam logic [2:0] DM_OP_BS = 3'd1;
    localparam logic [2:0] DM_OP_BZ = 3'd2;
    localparam logic [2:0] DM_OP_HS = 3'd3;
    localparam logic [2:0] DM_OP_HZ = 3'd4;
    localparam logic [2:0] DM_OP_SB = 3'd5;
    localparam logic [2:0] DM_OP_SH = 3'd6;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    function automatic logic is_store_op(input logic [2:0] op);
        return op inside {DM_OP_WD, DM_OP_SB, DM_OP_SH};
    endfunction

    function automatic logic is_load_op(input logic [2:0] op);
        return op inside {DM_OP_WD, DM_OP_BS, DM_OP_BZ, DM_OP_HS, DM_OP_HZ};
    endfunction

    function automatic logic op_align_ok(input logic [2:0] op, input logic [1:0] a);
        return (op == DM_OP_WD) ? (a == 2'b00) :
               (op inside {DM_OP_HS, DM_OP_HZ, DM_OP_SH}) ? !a[0] : 1'b1;
    endfunction
endpackage

// File: rtl/dm_arb_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; the requester other than last wins a tie
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    assign gnt_valid = |req;
    assign gnt_idx   = (&req) ? ~last : req[1];
endmodule

// File: rtl/dm_arb.sv
// dm_arb: shares the dm port between m0 (CPU) and m1 (debug/DMA), one checked access per 3 cycles
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [2:0]    m0_op,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [2:0]    m1_op,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          dm_w,
    output logic          dm_r,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic [2:0]    dm_op,
    input  logic [DW-1:0] dm_rdata
);
    state_t        state, state_n;
    logic          last, g, gv, gi, err_q, legal, sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [2:0]    sel_op;

    rr_arb2 u_rr (
        .req       ({m1_req, m0_req}),
        .last      (last),
        .gnt_valid (gv),
        .gnt_idx   (gi)
    );

    always_comb begin
        sel_we    = gi ? m1_we : m0_we;
        sel_addr  = gi ? m1_addr : m0_addr;
        sel_wdata = gi ? m1_wdata : m0_wdata;
        sel_op    = gi ? m1_op : m0_op;
        legal     = (sel_we ? is_store_op(sel_op) : is_load_op(sel_op)) && op_align_ok(sel_op, sel_addr[1:0]);
        state_n   = (state == IDLE) ? (gv ? ACCESS : IDLE) : (state == ACCESS) ? ACK : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // strobes and acks are set on the edge entering ACCESS/ACK so they are clean registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b1;
            g        <= 1'b0;
            err_q    <= 1'b0;
            dm_w     <= 1'b0;
            dm_r     <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_op    <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            dm_w   <= 1'b0;
            dm_r   <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            if (state == IDLE && gv) begin
                g        <= gi;
                last     <= gi;
                err_q    <= !legal;
                dm_w     <= sel_we && legal;
                dm_r     <= !sel_we && legal;
                dm_addr  <= sel_addr;
                dm_wdata <= sel_wdata;
                dm_op    <= sel_op;
            end
            if (state == ACCESS) begin
                m0_ack <= !g;
                m1_ack <= g;
                m0_err <= !g && err_q;
                m1_err <= g && err_q;
                if (dm_r && !g)
                    m0_rdata <= dm_rdata;
                if (dm_r && g)
                    m1_rdata <= dm_rdata;
            end
        end
    end
endmodule

// File: tb/tb_dm_arb.sv
// tb_dm_arb: randomized and directed accesses checked against a byte-level transaction model
module tb_dm_arb;
    import dm_arb_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req = '0, we = '0, ack, err;
    logic [1:0][31:0] addr = '0, wdata = '0, rdata;
    logic [1:0][2:0]  op = '0;
    logic             dm_w, dm_r;
    logic [31:0]      dm_addr, dm_wdata, dm_rdata, dm_word, dm_lane;
    logic [2:0]       dm_op;

    dm_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (req[0]),
        .m0_we    (we[0]),
        .m0_addr  (addr[0]),
        .m0_wdata (wdata[0]),
        .m0_op    (op[0]),
        .m0_ack   (ack[0]),
        .m0_err   (err[0]),
        .m0_rdata (rdata[0]),
        .m1_req   (req[1]),
        .m1_we    (we[1]),
        .m1_addr  (addr[1]),
        .m1_wdata (wdata[1]),
        .m1_op    (op[1]),
        .m1_ack   (ack[1]),
        .m1_err   (err[1]),
        .m1_rdata (rdata[1]),
        .dm_w     (dm_w),
        .dm_r     (dm_r),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_op    (dm_op),
        .dm_rdata (dm_rdata)
    );

    // dm stand-in: big-endian words, stores take pre-positioned byte lanes, loads return extended values
    logic [31:0] mem [16] = '{default: 32'h0};

    function automatic logic [31:0] lane_mask(input logic [2:0] o, input logic [1:0] a);
        return (o == DM_OP_SB) ? 32'hFF00_0000 >> (8 * a) :
               (o == DM_OP_SH) ? 32'hFFFF_0000 >> (8 * a) : 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk)
        if (dm_w)
            mem[dm_addr[5:2]] <= (mem[dm_addr[5:2]] & ~lane_mask(dm_op, dm_addr[1:0])) |
                                 (dm_wdata & lane_mask(dm_op, dm_addr[1:0]));

    always_comb begin
        dm_word  = mem[dm_addr[5:2]];
        dm_lane  = dm_word << (8 * dm_addr[1:0]);
        dm_rdata = (dm_op == DM_OP_BS) ? {{24{dm_lane[31]}}, dm_lane[31:24]} :
                   (dm_op == DM_OP_BZ) ? {24'h0, dm_lane[31:24]} :
                   (dm_op == DM_OP_HS) ? {{16{dm_lane[31]}}, dm_lane[31:16]} :
                   (dm_op == DM_OP_HZ) ? {16'h0, dm_lane[31:16]} : dm_word;
    end

    // reference model: byte array plus per-transaction phase (0 none, 1 access, 2 ack)
    logic [7:0]  rm [64] = '{default: 8'h0};
    logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
    int          phase = 0;
    logic        last = 1'b1, g = 1'b0, cur_err = 1'b0;
    txn_t        cur = '0;
    txn_t        q0[$], q1[$];
    int          n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
        txn_t t;
        t.we = w;
        t.addr = a;
        t.wdata = d;
        t.op = o;
        return t;
    endfunction

    function automatic logic ref_legal(input txn_t t);
        logic st = t.op inside {DM_OP_WD, DM_OP_SB, DM_OP_SH};
        logic ld = t.op inside {DM_OP_WD, DM_OP_BS, DM_OP_BZ, DM_OP_HS, DM_OP_HZ};
        int   sz = (t.op == DM_OP_WD) ? 4 : (t.op inside {DM_OP_HS, DM_OP_HZ, DM_OP_SH}) ? 2 : 1;
        return (t.we ? st : ld) && (t.addr % sz == 0);
    endfunction

    function automatic void ref_store(input txn_t t);
        int a = int'(t.addr[5:0]);
        int n = (t.op == DM_OP_SB) ? 1 : (t.op == DM_OP_SH) ? 2 : 4;
        for (int i = 0; i < n; i++)
            rm[a+i] = 8'(t.wdata >> (8 * (3 - (a % 4) - i)));
    endfunction

    function automatic logic [31:0] ref_load(input txn_t t);
        int a = int'(t.addr[5:0]);
        case (t.op)
            DM_OP_BS: return {{24{rm[a][7]}}, rm[a]};
            DM_OP_BZ: return {24'h0, rm[a]};
            DM_OP_HS: return {{16{rm[a][7]}}, rm[a], rm[a+1]};
            DM_OP_HZ: return {16'h0, rm[a], rm[a+1]};
            default:  return {rm[a], rm[a+1], rm[a+2], rm[a+3]};
        endcase
    endfunction

    function automatic txn_t rnd();
        logic [1:0] lo = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
        return mk(1'($urandom), {26'h0, 4'($urandom_range(0, 15)), lo}, $urandom, 3'($urandom_range(0, 7)));
    endfunction

    task automatic drive();
        txn_t t;
        for (int n = 0; n < 2; n++) begin
            if (phase == 2 && int'(g) == n)
                req[n] = 1'b0;
            else if (!req[n] && (n == 0 ? q0.size() : q1.size()) > 0) begin
                t = (n == 0) ? q0.pop_front() : q1.pop_front();
                req[n] = 1'b1;
                we[n] = t.we;
                addr[n] = t.addr;
                wdata[n] = t.wdata;
                op[n] = t.op;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (phase == 2)
            phase = 0;
        else if (phase == 1) begin
            if (!cur_err && cur.we)
                ref_store(cur);
            else if (!cur_err)
                exp_rd[g] = ref_load(cur);
            phase = 2;
        end else if (req != 2'b00) begin
            g = (req[0] && req[1]) ? !last : !req[0];
            last = g;
            cur = mk(we[g], addr[g], wdata[g], op[g]);
            cur_err = !ref_legal(cur);
            phase = 1;
        end
        #1;
        if (phase == 1) begin
            check("dm_w", dm_w, cur.we && !cur_err);
            check("dm_r", dm_r, !cur.we && !cur_err);
            check("ack_access", ack, 0);
        end else begin
            check("strobes", {dm_w, dm_r}, 0);
            check("ack", ack, (phase == 2) ? 2'b01 << g : 2'b00);
            check("err", err, (phase == 2 && cur_err) ? 2'b01 << g : 2'b00);
        end
        if (phase != 0) begin
            check("dm_addr", dm_addr, cur.addr);
            check("dm_wdata", dm_wdata, cur.wdata);
            check("dm_op", dm_op, cur.op);
        end
        check("m0_rdata", rdata[0], exp_rd[0]);
        check("m1_rdata", rdata[1], exp_rd[1]);
        drive();
    endtask

    task automatic drain(input string tag);
        int i = 0;
        drive();
        while ((q0.size() > 0 || q1.size() > 0 || req != 2'b00 || phase != 0) && i < 300) begin
            step();
            i++;
        end
        check(tag, i >= 300, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {dm_w, dm_r, ack, err, dm_op}, 0);
        check({tag, "_addr"}, dm_addr, 0);
        check({tag, "_wdata"}, dm_wdata, 0);
        check({tag, "_rd0"}, rdata[0], 0);
        check({tag, "_rd1"}, rdata[1], 0);
    endtask

    task automatic model_reset();
        phase = 0;
        last = 1'b1;
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        req = 2'b00;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10 check_zero("rst");
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 32'h0, 32'h0, DM_OP_WD));
            q1.push_back(mk(1'b0, 32'h4, 32'h0, DM_OP_WD));
        end
        drain("contend");

        q0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, DM_OP_WD));
        q0.push_back(mk(1'b0, 32'h10, 32'h0, DM_OP_WD));
        drain("word_rw");
        check("word_rd_val", rdata[0], 32'hDEAD_BEEF);

        q1.push_back(mk(1'b1, 32'h20, 32'h1122_3344, DM_OP_WD));
        q1.push_back(mk(1'b1, 32'h20, 32'hAB00_0000, DM_OP_SB));
        q1.push_back(mk(1'b0, 32'h20, 32'h0, DM_OP_BZ));
        drain("byte_rw");
        check("byte_rd_val", rdata[1], 32'h0000_00AB);

        q0.push_back(mk(1'b0, 32'h12, 32'h0, DM_OP_WD));
        q0.push_back(mk(1'b1, 32'h10, 32'h5555_5555, DM_OP_BS));
        q0.push_back(mk(1'b0, 32'h10, 32'h0, DM_OP_WD));
        drain("illegal");
        check("illegal_mem", rdata[0], 32'hDEAD_BEEF);

        q1.push_back(mk(1'b0, 32'h4, 32'h0, DM_OP_WD));
        drive();
        for (int i = 0; i < 10 && phase != 1; i++)
            step();
        check("reach_access", phase, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_access");
        model_reset();
        @(posedge clk);
        #1 check_zero("rst_hold");
        @(negedge clk) rst_n = 1'b1;
        q0.push_back(mk(1'b0, 32'h20, 32'h0, DM_OP_HZ));
        q1.push_back(mk(1'b0, 32'h10, 32'h0, DM_OP_BS));
        drain("post_rst");

        repeat (1500) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0)
                q0.push_back(rnd());
            if (q1.size() == 0 && $urandom_range(0, 2) == 0)
                q1.push_back(rnd());
            step();
        end
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dm_arb.md
# dm_arb

Two-requester arbiter and access sequencer for the data memory `dm`. It shares the single `dm` port between the CPU memory stage (m0) and the debug/DMA loader (m1). It uses round-robin arbitration and a req/ack handshake. It checks op/alignment legality before touching memory, registers all `dm` control outputs and captures read data into a per-access response register.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `m0_req`  in  1  CPU access request, held until `m0_ack`
- `m0_we`  in  1  1 = store, 0 = load
- `m0_addr`  in  AW  byte address
- `m0_wdata`  in  DW  store data
- `m0_op`  in  3  `DM_OP_*` code from `common.v`
- `m0_ack`  out  1  one-cycle completion pulse
- `m0_err`  out  1  valid with `m0_ack`; access rejected
- `m0_rdata`  out  DW  load result, valid with `m0_ack`
- `m1_*`  same set and widths as m0, for the debug/DMA requester
- `dm_w`, `dm_r`  out  1  memory write/read strobes
- `dm_addr`  out  AW  memory address
- `dm_wdata`  out  DW  memory write data
- `dm_op`  out  3  memory op code
- `dm_rdata`  in  DW  combinational read data from `dm`

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE:**
  - With no request, stay in IDLE.
  - With any `mN_req`, grant a requester, latch its `we/addr/wdata/op` into the `dm_*` registers, and go to ACCESS.
- **Arbitration:** round-robin on `last` (1 bit = index of the last granted requester).
  - Only one requesting: it wins.
  - Both requesting: the requester not equal to `last` wins.
  - `last` updates on grant.
- **Legality check at grant:**
  - Store ops: `DM_OP_WD`, `DM_OP_SB`, `DM_OP_SH`. Load ops: `DM_OP_BS`, `DM_OP_BZ`, `DM_OP_HS`, `DM_OP_HZ`, `DM_OP_WD`.
  - Word op requires `addr[1:0]==0`. Half op requires `addr[0]==0`.
  - An illegal op for the direction, or a misaligned address, sets `err_q`.
- **ACCESS:** exactly one cycle.
  - If `!err_q`, assert `dm_w` (store) or `dm_r` (load). The write commits at the clock edge ending ACCESS.
  - For a load, capture `dm_rdata` into the granted `mN_rdata` at that edge.
  - If `err_q`, assert no strobe and leave `rdata` unchanged.
  - Go to ACK.
- **ACK:**
  - Pulse the granted `mN_ack` for one cycle, and `mN_err = err_q`.
  - Drop strobes and go to IDLE.
  - The requester must drop `req` in the cycle after ack.
- The ungranted requester's `ack`/`err` stay 0 throughout.

## Timing
- Request sampled in IDLE at cycle t: ACCESS at t+1, ack at t+2. Next grant no earlier than t+3.
- Throughput: one access per 3 cycles.
- Under continuous contention, grants alternate m0, m1, m0, …
- `dm_addr/dm_wdata/dm_op` are held stable through ACCESS and ACK.
- `dm_r`/`dm_w` are high only in the ACCESS cycle, never both.
- Reset (async assert, any state):
  - State = IDLE, `last` = 1, so m0 wins first contention.
  - All outputs are 0: `dm_w`, `dm_r`, `dm_addr`, `dm_wdata`, `dm_op`, `mN_ack`, `mN_err`, `mN_rdata`.
  - An access interrupted mid-ACCESS is abandoned with no ack. A store may or may not have committed, depending on whether the edge preceded reset.
- Reset deassertion: the first grant is possible on the first clock edge with `rst_n` high.
- A `req` that drops before ack is a protocol violation. The FSM still completes the access and pulses ack.

## Structure
- `DM_OP_*` codes come from the existing `common.v`. Add `is_store_op`/`is_load_op`/`op_align_ok` helper functions there, for reuse by the pipeline hazard logic.
- One sub-module is natural: `rr_arb2` (combinational 2-way round-robin pick from `req[1:0]` and `last`). The FSM, check and response registers stay in `dm_arb`.

## Test plan
- m0 store `DM_OP_WD` addr 0x10 data 0xDEADBEEF, then m0 load `DM_OP_WD` 0x10 -> `dm_w` one cycle; ack at t+2 for each; load rdata 0xDEADBEEF, err 0.
- m0 and m1 request the same cycle after reset, with m0 load 0x0 and m1 load 0x4 -> m0 acked first; m1 granted at t+3 and acked at t+5; repeat continuously -> strict alternation.
- m1 store `DM_OP_SB` 0x20 data 0xAB000000 over word 0x11223344, then load `DM_OP_BZ` 0x20 -> rdata 0x000000AB.
- m0 load `DM_OP_WD` addr 0x12 (misaligned) and m0 store `DM_OP_BS` (illegal) -> ack with err 1; `dm_r`/`dm_w` never asserted; memory unchanged.
- `rst_n` asserted low during ACCESS of m1 load -> all outputs 0 immediately; no m1 ack; after release, m0 wins a simultaneous request.
